// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic 6-tap FIR engine (LUT reader side).
// Ports: clk, rst_n, in_data/in_valid/in_ready, flush, lut_addr/lut_data, y_out/out_valid/out_ready.
module da_fir_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = DATA_W + 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [5:0]               lut_addr,
  input  logic [5:0]               lut_data,
  output logic signed [ACC_W-1:0]  y_out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state;
  logic [DATA_W-1:0]        taps [6];
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         bit_cnt;
  logic signed [ACC_W-1:0]  slice_sh;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    lut_addr = '0;
    if (state == S_RUN) begin
      for (int k = 0; k < 6; k++) begin
        lut_addr[k] = taps[k][bit_cnt];
      end
    end
  end

  // partial sum weighted by the current bit position
  assign slice_sh =
    {{(ACC_W-6){lut_data[5]}}, lut_data} <<< bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      bit_cnt <= '0;
      y_out   <= '0;
      for (int k = 0; k < 6; k++) begin
        taps[k] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (flush) begin
            for (int k = 0; k < 6; k++) begin
              taps[k] <= '0;
            end
          end else if (in_valid) begin
            for (int k = 5; k > 0; k--) begin
              taps[k] <= taps[k-1];
            end
            taps[0] <= in_data;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (bit_cnt == LAST) begin
            // sign slice carries negative weight
            y_out   <= acc - slice_sh;
            bit_cnt <= '0;
            state   <= S_DONE;
          end else begin
            acc     <= acc + slice_sh;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_fir_engine.sv
// Self-checking bench for da_fir_engine with an external DA LUT model.
// Compares results against a direct-form convolution reference.
module tb_da_fir_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = DATA_W + 6;

  logic                    clk;
  logic                    rst_n;
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [5:0]              lut_addr;
  logic [5:0]              lut_data;
  logic signed [ACC_W-1:0] y_out;
  logic                    out_valid;
  logic                    out_ready;

  int checks;
  int errors;
  int h [6] = '{7, -7, 5, 5, -5, 3};
  int hist [6];

  da_fir_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external LUT: sum of coefficients selected by address bits
  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < 6; k++) begin
      if (lut_addr[k]) s = s + h[k];
    end
    lut_data = s[5:0];
  end

  function automatic int model_push(input int x);
    int y;
    for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    y = 0;
    for (int k = 0; k < 6; k++) y = y + h[k] * hist[k];
    return y;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 6; k++) hist[k] = 0;
  endfunction

  // Drive one sample, wait for result, take it. No checking here.
  task automatic send(input int x, output int y, output int cyc,
                      output bit ok);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_data  = DATA_W'(x);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    ok = out_valid && (w < 40);
    y = int'(y_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (y_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        lut_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset: y=%0d ov=%b ir=%b addr=%h, want 0 0 1 0",
               y_out, out_valid, in_ready, lut_addr);
    end
  endtask

  task automatic test_impulse();
    int xs [7] = '{1, 0, 0, 0, 0, 0, 0};
    int y, cyc, e;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      e = model_push(xs[i]);
      send(xs[i], y, cyc, ok);
      checks++;
      if (!ok || y !== e) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d ok=%b, want %0d", i, y, ok, e);
      end
      if (i == 0) begin
        checks++;
        if (cyc !== DATA_W) begin
          errors++;
          $display("FAIL latency: got %0d, want %0d", cyc, DATA_W);
        end
      end
    end
  endtask

  task automatic test_min();
    int y, cyc, e;
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      e = model_push(-128);
      send(-128, y, cyc, ok);
      checks++;
      if (!ok || y !== e) begin
        errors++;
        $display("FAIL min[%0d]: got %0d, want %0d", i, y, e);
      end
    end
  endtask

  task automatic test_extreme();
    int xs [6] = '{127, -128, 127, 127, -128, 127};
    int y, cyc, e;
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      e = model_push(xs[i]);
      send(xs[i], y, cyc, ok);
      checks++;
      if (!ok || y !== e) begin
        errors++;
        $display("FAIL extreme[%0d]: got %0d, want %0d", i, y, e);
      end
    end
    checks++;
    if (y !== 4076) begin
      errors++;
      $display("FAIL extreme_last: got %0d, want 4076", y);
    end
  endtask

  task automatic test_backpressure();
    int e, y, cyc;
    bit ok;
    logic signed [ACC_W-1:0] held;
    e = model_push(3);
    in_data  = DATA_W'(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    held = y_out;
    checks++;
    if (!out_valid || int'(held) !== e) begin
      errors++;
      $display("FAIL bp_result: got %0d ov=%b, want %0d", held, out_valid, e);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom_range(0, 255));
      @(posedge clk); #1;
      checks++;
      if (y_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: y=%0d ov=%b ir=%b, want %0d 1 0",
                 i, y_out, out_valid, in_ready, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    e = model_push(-2);
    send(-2, y, cyc, ok);
    checks++;
    if (!ok || y !== e) begin
      errors++;
      $display("FAIL bp_next: got %0d, want %0d", y, e);
    end
  endtask

  task automatic test_reset_mid_run();
    int y, cyc, e;
    bit ok;
    in_data  = DATA_W'(5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_out !== '0 || out_valid !== 1'b0 || lut_addr !== 6'd0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: y=%0d ov=%b addr=%h ir=%b, want 0 0 0 1",
               y_out, out_valid, lut_addr, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    e = model_push(1);
    send(1, y, cyc, ok);
    checks++;
    if (!ok || y !== e || y !== 7) begin
      errors++;
      $display("FAIL after_reset: got %0d, want 7", y);
    end
  endtask

  task automatic test_flush();
    int y, cyc, e;
    bit ok;
    e = model_push(1);
    send(1, y, cyc, ok);
    e = model_push(2);
    send(2, y, cyc, ok);
    checks++;
    if (!ok || y !== e) begin
      errors++;
      $display("FAIL pre_flush: got %0d, want %0d", y, e);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DATA_W'(9);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    e = model_push(0);
    send(0, y, cyc, ok);
    checks++;
    if (!ok || y !== e || y !== 0) begin
      errors++;
      $display("FAIL flush_zero: got %0d, want 0", y);
    end
    e = model_push(1);
    send(1, y, cyc, ok);
    checks++;
    if (!ok || y !== e || y !== 7) begin
      errors++;
      $display("FAIL flush_one: got %0d, want 7", y);
    end
  endtask

  task automatic test_random();
    int y, cyc, e, x;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end
      x = int'($signed(8'($urandom_range(0, 255))));
      e = model_push(x);
      send(x, y, cyc, ok);
      checks++;
      if (!ok || y !== e) begin
        errors++;
        $display("FAIL random[%0d]: x=%0d got %0d, want %0d", i, x, y, e);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_impulse();
    test_min();
    test_extreme();
    test_backpressure();
    test_reset_mid_run();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
